// File: rtl/axi4lite_pkg.sv
// Shared definitions for the AXI4-Lite register-file responder.
//   - AXI response codes driven on bresp/rresp
//   - byte offsets of the register bank
package axi4lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] REG_CTRL      = 2'd0;
   localparam logic [1:0] REG_IRQ_MASK  = 2'd1;
   localparam logic [1:0] REG_STATUS    = 2'd2;
   localparam logic [1:0] REG_IRQ_FLAGS = 2'd3;

endpackage

// File: rtl/axi4lite_wr_hold.sv
// Single-entry capture register for one AXI write channel (AW, or W+strobe).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   valid      : channel valid from the master
//   data       : channel payload
//   clear      : consume the held entry (write commit)
//   ready      : channel ready back to the master, registered
//   full       : an entry is held
//   q          : held payload
module axi4lite_wr_hold #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         valid,
   input  logic [W-1:0] data,
   input  logic         clear,
   output logic         ready,
   output logic         full,
   output logic [W-1:0] q
);

   logic         full_q, full_d;
   logic         ready_q, ready_d;
   logic [W-1:0] data_q, data_d;

   // ready is a flop (not !full) so it can sit at 0 during reset and
   // rise only on the first edge after reset is released.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (clear) full_d = 1'b0;
      if (valid && ready_q) begin
         full_d = 1'b1;
         data_d = data;
      end
      ready_d = !full_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q  <= 1'b0;
         ready_q <= 1'b0;
         data_q  <= '0;
      end else begin
         full_q  <= full_d;
         ready_q <= ready_d;
         data_q  <= data_d;
      end
   end

   assign ready = ready_q;
   assign full  = full_q;
   assign q     = data_q;

endmodule

// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite responder exposing a four-entry control/status register bank.
//   0x0 CTRL (rw), 0x1 IRQ_MASK (rw), 0x2 STATUS (ro, live status_in),
//   0x3 IRQ_FLAGS (write-1-to-clear, set by irq_event_in); 0x4+ DECERR.
// Ports:
//   s_axi_aclk / s_axi_aresetn : clock, asynchronous active-low reset
//   s_axi_aw* / s_axi_w* / s_axi_b* : write address, data, response
//   s_axi_ar* / s_axi_r*            : read address, data
//   ctrl_out     : CTRL contents
//   status_in    : hardware status returned on STATUS reads
//   irq_event_in : per-bit set pulses for IRQ_FLAGS
//   irq_out      : registered |(IRQ_FLAGS & IRQ_MASK)
module axi4lite_regfile_slave #(
   parameter int                    ADDR_WIDTH = 3,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] CTRL_RESET = '0
) (
   input  logic                    s_axi_aclk,
   input  logic                    s_axi_aresetn,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready,
   output logic [DATA_WIDTH-1:0]   ctrl_out,
   input  logic [DATA_WIDTH-1:0]   status_in,
   input  logic [DATA_WIDTH-1:0]   irq_event_in,
   output logic                    irq_out
);

   import axi4lite_pkg::*;

   localparam int STRB_W = DATA_WIDTH / 8;

   // ---------------- write channel holds ----------------
   logic                         aw_full, w_full, commit;
   logic [ADDR_WIDTH-1:0]        aw_addr;
   logic [STRB_W+DATA_WIDTH-1:0] w_hold;
   logic [DATA_WIDTH-1:0]        w_data, wmask;
   logic [STRB_W-1:0]            w_strb;

   axi4lite_wr_hold #(.W(ADDR_WIDTH)) u_aw_hold (
      .clk   (s_axi_aclk),
      .rst_n (s_axi_aresetn),
      .valid (s_axi_awvalid),
      .data  (s_axi_awaddr),
      .clear (commit),
      .ready (s_axi_awready),
      .full  (aw_full),
      .q     (aw_addr)
   );

   axi4lite_wr_hold #(.W(STRB_W + DATA_WIDTH)) u_w_hold (
      .clk   (s_axi_aclk),
      .rst_n (s_axi_aresetn),
      .valid (s_axi_wvalid),
      .data  ({s_axi_wstrb, s_axi_wdata}),
      .clear (commit),
      .ready (s_axi_wready),
      .full  (w_full),
      .q     (w_hold)
   );

   assign {w_strb, w_data} = w_hold;

   // Commit is held off while a response is outstanding; the holds then
   // stay full and backpressure AW/W on their own.
   assign commit = aw_full && w_full && !s_axi_bvalid;

   always_comb begin
      for (int b = 0; b < STRB_W; b++) wmask[b*8 +: 8] = {8{w_strb[b]}};
   end

   // ---------------- register bank state ----------------
   logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
   logic [DATA_WIDTH-1:0] mask_q, mask_d;
   logic [DATA_WIDTH-1:0] flags_q, flags_d, flags_clr;
   logic                  irq_q, irq_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  wr_in_range;
   logic [1:0]            wr_idx;

   assign wr_in_range = (aw_addr >> 2) == '0;
   assign wr_idx      = aw_addr[1:0];

   always_comb begin
      ctrl_d    = ctrl_q;
      mask_d    = mask_q;
      flags_clr = '0;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
      if (commit) begin
         bvalid_d = 1'b1;
         bresp_d  = RESP_OKAY;
         if (!wr_in_range) begin
            bresp_d = RESP_DECERR;
         end else begin
            case (wr_idx)
               REG_CTRL:      ctrl_d    = (ctrl_q & ~wmask) | (w_data & wmask);
               REG_IRQ_MASK:  mask_d    = (mask_q & ~wmask) | (w_data & wmask);
               REG_STATUS:    bresp_d   = RESP_SLVERR;
               REG_IRQ_FLAGS: flags_clr = w_data & wmask;
               default:       bresp_d   = RESP_DECERR;
            endcase
         end
      end
      // An event pulse overrides a same-cycle clear on the same bit.
      flags_d = (flags_q & ~flags_clr) | irq_event_in;
      irq_d   = |(flags_q & mask_q);
   end

   // ---------------- read path ----------------
   logic                  ar_hs;
   logic                  arready_q, arready_d;
   logic                  rvalid_q, rvalid_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   assign ar_hs = s_axi_arvalid && arready_q;

   // Reads sample the bank before this cycle's commit, so a same-cycle
   // read of a register being written returns the old value.
   always_comb begin
      rvalid_d = rvalid_q;
      rresp_d  = rresp_q;
      rdata_d  = rdata_q;
      if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rresp_d  = RESP_OKAY;
         rdata_d  = '0;
         if ((s_axi_araddr >> 2) != '0) begin
            rresp_d = RESP_DECERR;
         end else begin
            case (s_axi_araddr[1:0])
               REG_CTRL:      rdata_d = ctrl_q;
               REG_IRQ_MASK:  rdata_d = mask_q;
               REG_STATUS:    rdata_d = status_in;
               REG_IRQ_FLAGS: rdata_d = flags_q;
               default:       rdata_d = '0;
            endcase
         end
      end
      arready_d = !rvalid_d;
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         ctrl_q    <= CTRL_RESET;
         mask_q    <= '0;
         flags_q   <= '0;
         irq_q     <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         mask_q    <= mask_d;
         flags_q   <= flags_d;
         irq_q     <= irq_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
      end
   end

   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rdata   = rdata_q;
   assign ctrl_out      = ctrl_q;
   assign irq_out       = irq_q;

endmodule
